// File: rtl/pb_timer_irq_pkg.sv
// pb_timer_irq_pkg: register map, bit indices and defaults for the port-mapped timer
package pb_timer_irq_pkg;
  localparam logic [7:0] BASE_ADDR_DEF = 8'h10;
  localparam int NUM_REGS = 7;
  localparam int CTRL_EN = 0;
  localparam int CTRL_AUTO = 1;
  localparam int CTRL_IRQ_EN = 2;
  localparam int ST_EXPIRED = 0;
  localparam int ST_PEND = 1;
  localparam int ST_OVR = 2;
  typedef enum logic [2:0] {
    OFF_CTRL,
    OFF_PRESC,
    OFF_RLD_LO,
    OFF_RLD_HI,
    OFF_CNT_LO,
    OFF_CNT_HI,
    OFF_STATUS
  } reg_off_e;
endpackage

// File: rtl/pb_timer_irq_if.sv
// pb_timer_irq_if: processor I/O port bus between the soft core and its peripherals
interface pb_timer_irq_if;
  logic [7:0] port_id;
  logic [7:0] out_port;
  logic       write_strobe;
  logic       read_strobe;
  logic [7:0] in_port;
  logic       interrupt;
  logic       interrupt_ack;
  modport master (
    output port_id, out_port, write_strobe, read_strobe, interrupt_ack,
    input  in_port, interrupt
  );
  modport slave (
    input  port_id, out_port, write_strobe, read_strobe, interrupt_ack,
    output in_port, interrupt
  );
endinterface

// File: rtl/pb_timer_irq_core.sv
// pb_timer_irq_core: prescaler plus 16-bit down counter producing the expire event
module pb_timer_irq_core #(
  parameter int PRESCALE_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_en,
  input  logic                  i_ctrl_wr,
  input  logic                  i_auto,
  input  logic                  i_load,
  input  logic [PRESCALE_W-1:0] i_presc,
  input  logic [15:0]           i_load_val,
  input  logic [15:0]           i_reload,
  output logic [15:0]           o_count,
  output logic                  o_expire
);
  logic [PRESCALE_W-1:0] r_presc_cnt;
  logic [15:0]           r_count;
  logic                  w_tick;
  // a CTRL write restarts the prescaler and swallows any tick due on that clock
  assign w_tick   = i_en && !i_ctrl_wr && r_presc_cnt == i_presc;
  assign o_expire = w_tick && !i_load && r_count <= 16'd1;
  assign o_count  = r_count;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_presc_cnt <= '0;
      r_count     <= '0;
    end else begin
      r_presc_cnt <= (!i_en || i_ctrl_wr || w_tick) ? '0 : r_presc_cnt + 1'b1;
      r_count     <= i_load ? i_load_val : o_expire ? (i_auto ? i_reload : 16'd0) : w_tick ? r_count - 16'd1 : r_count;
    end
  end
endmodule

// File: rtl/pb_timer_irq.sv
// pb_timer_irq: port-mapped programmable timer with sticky status and level interrupt
module pb_timer_irq
  import pb_timer_irq_pkg::*;
#(
  parameter logic [7:0] BASE_ADDR  = BASE_ADDR_DEF,
  parameter int         PRESCALE_W = 8
) (
  input logic           clk,
  input logic           rst,
  pb_timer_irq_if.slave s_bus
);
  logic [2:0]            r_ctrl;
  logic [PRESCALE_W-1:0] r_presc;
  logic [7:0]            r_rld_lo;
  logic [7:0]            r_rld_hi;
  logic [7:0]            r_cnt_hi;
  logic [2:0]            r_status;
  logic [7:0]            r_in_port;
  logic [7:0]            w_off;
  logic [7:0]            w_rd;
  logic [15:0]           w_count;
  logic [2:0]            w_w1c;
  reg_off_e              w_sel;
  logic                  w_hit;
  logic                  w_we;
  logic                  w_wr_ctrl;
  logic                  w_wr_hi;
  logic                  w_expire;
  logic                  w_irq_set;
  logic                  w_ack;
  assign w_off     = s_bus.port_id - BASE_ADDR;
  assign w_hit     = w_off < 8'(NUM_REGS);
  assign w_sel     = reg_off_e'(w_off[2:0]);
  assign w_we      = s_bus.write_strobe && w_hit;
  assign w_wr_ctrl = w_we && w_sel == OFF_CTRL;
  assign w_wr_hi   = w_we && w_sel == OFF_RLD_HI;
  assign w_w1c     = (w_we && w_sel == OFF_STATUS) ? s_bus.out_port[2:0] : 3'd0;
  assign w_irq_set = w_expire && r_ctrl[CTRL_IRQ_EN];
  assign w_ack     = s_bus.interrupt_ack;
  pb_timer_irq_core #(.PRESCALE_W(PRESCALE_W)) u_core (
    .clk       (clk),
    .rst       (rst),
    .i_en      (r_ctrl[CTRL_EN]),
    .i_ctrl_wr (w_wr_ctrl),
    .i_auto    (r_ctrl[CTRL_AUTO]),
    .i_load    (w_wr_hi),
    .i_presc   (r_presc),
    .i_load_val({s_bus.out_port, r_rld_lo}),
    .i_reload  ({r_rld_hi, r_rld_lo}),
    .o_count   (w_count),
    .o_expire  (w_expire)
  );
  always_comb begin
    w_rd = 8'h00;
    if (w_hit)
      case (w_sel)
        OFF_CTRL:   w_rd = {5'd0, r_ctrl};
        OFF_PRESC:  w_rd = 8'(r_presc);
        OFF_RLD_LO: w_rd = r_rld_lo;
        OFF_RLD_HI: w_rd = r_rld_hi;
        OFF_CNT_LO: w_rd = w_count[7:0];
        OFF_CNT_HI: w_rd = r_cnt_hi;
        OFF_STATUS: w_rd = {5'd0, r_status};
        default:    w_rd = 8'h00;
      endcase
  end
  // status set terms sit outside the clear masks so an expire beats a same-clock ack or W1C
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ctrl    <= '0;
      r_presc   <= '0;
      r_rld_lo  <= '0;
      r_rld_hi  <= '0;
      r_cnt_hi  <= '0;
      r_status  <= '0;
      r_in_port <= '0;
    end else begin
      if (w_wr_ctrl) r_ctrl <= s_bus.out_port[2:0];
      else if (w_expire && !r_ctrl[CTRL_AUTO]) r_ctrl[CTRL_EN] <= 1'b0;
      if (w_we && w_sel == OFF_PRESC) r_presc <= s_bus.out_port[PRESCALE_W-1:0];
      if (w_we && w_sel == OFF_RLD_LO) r_rld_lo <= s_bus.out_port;
      if (w_wr_hi) r_rld_hi <= s_bus.out_port;
      if (s_bus.read_strobe && w_hit && w_sel == OFF_CNT_LO) r_cnt_hi <= w_count[15:8];
      r_status[ST_EXPIRED] <= w_expire | (r_status[ST_EXPIRED] & ~w_w1c[ST_EXPIRED]);
      r_status[ST_PEND]    <= w_irq_set | (r_status[ST_PEND] & ~w_w1c[ST_PEND] & ~w_ack);
      r_status[ST_OVR]     <= (w_irq_set & r_status[ST_PEND] & ~w_ack) | (r_status[ST_OVR] & ~w_w1c[ST_OVR]);
      r_in_port <= w_rd;
    end
  end
  assign s_bus.in_port   = r_in_port;
  assign s_bus.interrupt = r_status[ST_PEND];
endmodule
